// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: brings up the PLL, then releases reset domains in order.
// Retries on lock timeout, re-sequences on lock loss or software request.
module clk_rst_seq #(
    parameter int unsigned N_DOM        = 3,
    parameter int unsigned PLL_RST_CYC  = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned STAGE_DLY    = 16,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pll_locked_i,
    input  logic             sw_rst_req_i,
    output logic             pll_rst_o,
    output logic [N_DOM-1:0] dom_rst_n_o,
    output logic             ready_o,
    output logic             fault_o,
    output logic [7:0]       lock_loss_cnt_o
);

    localparam int unsigned REL_CYC = N_DOM * STAGE_DLY;
    localparam int unsigned MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > REL_CYC) ? MAX_AB : REL_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             sync_q, sync_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_rst_q, pll_rst_d;
    logic [N_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [7:0]       loss_q, loss_d;
    logic [RTY_W-1:0] rty_inc;
    logic             abort;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            rty_q       <= '0;
            sync_q      <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            dom_rst_n_q <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rty_q       <= rty_d;
            sync_q      <= sync_d;
            lock_s_q    <= lock_s_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_n_q <= dom_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            loss_q      <= loss_d;
        end
    end

    // Next-state and next-output logic; abort (sw request, lock loss) overrides sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rty_d       = rty_q;
        sync_d      = pll_locked_i;
        lock_s_d    = sync_q;
        pll_rst_d   = pll_rst_q;
        dom_rst_n_d = dom_rst_n_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        loss_d      = loss_q;
        rty_inc     = rty_q + RTY_W'(1);
        abort       = 1'b0;

        // Lock loss in RUN is counted even when a sw request wins priority
        if (state_q == S_RUN && !lock_s_q && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end

        if (sw_rst_req_i) begin
            abort = 1'b1;
        end else if ((state_q == S_RELEASE || state_q == S_RUN) && !lock_s_q) begin
            abort = 1'b1;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    pll_rst_d   = 1'b1;
                    dom_rst_n_d = '0;
                    ready_d     = 1'b0;
                    if (cnt_q == CNT_W'(PLL_RST_CYC - 1)) begin
                        state_d   = S_WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        rty_d     = rty_inc;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        if (rty_inc == RTY_W'(MAX_RETRY)) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = S_PLL_RST;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (dom_rst_n_q[N_DOM-1]) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        for (int k = 0; k < N_DOM; k++) begin
                            if (cnt_q == CNT_W'((k + 1) * STAGE_DLY - 1)) begin
                                dom_rst_n_d[k] = 1'b1;
                            end
                        end
                    end
                end
                S_RUN, S_FAULT: begin
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    rty_d   = '0;
                end
            endcase
        end

        if (abort) begin
            state_d     = S_PLL_RST;
            cnt_d       = '0;
            rty_d       = '0;
            pll_rst_d   = 1'b1;
            dom_rst_n_d = '0;
            ready_d     = 1'b0;
            fault_d     = 1'b0;
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign dom_rst_n_o     = dom_rst_n_q;
    assign ready_o         = ready_q;
    assign fault_o         = fault_q;
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: directed vector table, corner-case sequences and
// random stimulus, all checked against a phase/elapsed-time reference model.
module tb_clk_rst_seq;

    localparam int N_DOM = 3;
    localparam int PRC   = 8;
    localparam int LT    = 1024;
    localparam int SD    = 16;
    localparam int MR    = 3;

    localparam int PH_PRST  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sw = 1'b0;
    logic             lock = 1'b0;
    logic             pll_rst_o;
    logic [N_DOM-1:0] dom_rst_n_o;
    logic             ready_o;
    logic             fault_o;
    logic [7:0]       lock_loss_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    int m_ph = PH_PRST;
    int m_t = 0;
    int m_fails = 0;
    int m_loss = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .N_DOM(N_DOM), .PLL_RST_CYC(PRC), .LOCK_TIMEOUT(LT),
        .STAGE_DLY(SD), .MAX_RETRY(MR)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pll_locked_i(lock), .sw_rst_req_i(sw),
        .pll_rst_o(pll_rst_o), .dom_rst_n_o(dom_rst_n_o), .ready_o(ready_o),
        .fault_o(fault_o), .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    typedef struct {
        bit         rst_n;
        bit         sw;
        bit         lock;
        int         n;
        bit         pll;
        logic [2:0] dom;
        bit         rdy;
        bit         flt;
        int         loss;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        else n_pass++;
    endtask

    // Model: phase plus edges elapsed in that phase; outputs derived arithmetically
    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            m_ph = PH_PRST; m_t = 0; m_fails = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        ls = m_s2; m_s2 = m_s1; m_s1 = lock;
        if (m_ph == PH_RUN && !ls && m_loss < 255) m_loss++;
        if (sw || ((m_ph == PH_REL || m_ph == PH_RUN) && !ls)) begin
            m_ph = PH_PRST; m_t = 0; m_fails = 0;
        end else begin
            case (m_ph)
                PH_PRST: if (m_t == PRC - 1) begin m_ph = PH_WAIT; m_t = 0; end else m_t++;
                PH_WAIT: begin
                    if (ls) begin m_ph = PH_REL; m_t = 0; m_fails = 0; end
                    else if (m_t == LT - 1) begin
                        m_fails++; m_t = 0;
                        m_ph = (m_fails == MR) ? PH_FAULT : PH_PRST;
                    end else m_t++;
                end
                PH_REL: if (m_t == N_DOM * SD) m_ph = PH_RUN; else m_t++;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_outs();
        logic [N_DOM-1:0] dm;
        int stages;
        dm = '0;
        stages = 0;
        if (m_ph == PH_REL) stages = (m_t / SD > N_DOM) ? N_DOM : m_t / SD;
        if (m_ph == PH_RUN) stages = N_DOM;
        for (int i = 0; i < N_DOM; i++) if (i < stages) dm[i] = 1'b1;
        return 32'({(m_ph == PH_PRST || m_ph == PH_FAULT), dm, (m_ph == PH_RUN),
                    (m_ph == PH_FAULT), 8'(m_loss)});
    endfunction

    function automatic logic [31:0] dut_outs();
        return 32'({pll_rst_o, dom_rst_n_o, ready_o, fault_o, lock_loss_cnt_o});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model {pll,dom,rdy,flt,loss}", dut_outs(), model_outs());
    endtask

    task automatic wait_ready(input int budget);
        int i;
        i = 0;
        while (!ready_o && i < budget) begin tick(); i++; end
        check("wait_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        int falls;
        bit prev;
        int i;

        vt[0]  = '{0, 0, 1, 3,  1, 3'b000, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 7,  1, 3'b000, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 1,  0, 3'b000, 0, 0, 0};
        vt[3]  = '{1, 0, 1, 17, 0, 3'b001, 0, 0, 0};
        vt[4]  = '{1, 0, 1, 16, 0, 3'b011, 0, 0, 0};
        vt[5]  = '{1, 0, 1, 16, 0, 3'b111, 0, 0, 0};
        vt[6]  = '{1, 0, 1, 1,  0, 3'b111, 1, 0, 0};
        vt[7]  = '{1, 0, 0, 1,  0, 3'b111, 1, 0, 0};
        vt[8]  = '{1, 0, 1, 1,  0, 3'b111, 1, 0, 0};
        vt[9]  = '{1, 0, 1, 1,  1, 3'b000, 0, 0, 1};
        vt[10] = '{1, 0, 1, 58, 0, 3'b111, 1, 0, 1};
        vt[11] = '{1, 1, 1, 1,  1, 3'b000, 0, 0, 1};
        vt[12] = '{1, 0, 1, 8,  0, 3'b000, 0, 0, 1};

        for (int v = 0; v < 13; v++) begin
            rst_n = vt[v].rst_n; sw = vt[v].sw; lock = vt[v].lock;
            for (int c = 0; c < vt[v].n; c++) tick();
            check($sformatf("vec%0d", v), dut_outs(),
                  32'({vt[v].pll, vt[v].dom, vt[v].rdy, vt[v].flt, 8'(vt[v].loss)}));
        end

        // Lock never arrives: three PLL reset pulses, then fault
        lock = 0; sw = 1; tick(); sw = 0;
        falls = 0; prev = pll_rst_o;
        for (int c = 0; c < MR * (PRC + LT) + 5; c++) begin
            tick();
            if (prev && !pll_rst_o) falls++;
            prev = pll_rst_o;
        end
        check("timeout_pulses", 32'(falls), 32'd3);
        check("fault_set", 32'({fault_o, pll_rst_o}), 32'b11);
        sw = 1; tick(); sw = 0;
        check("fault_cleared", 32'({fault_o, pll_rst_o}), 32'b01);

        // Lock on second attempt, then a full set of retries is still available
        for (int c = 0; c < PRC + LT - 1; c++) tick();
        lock = 1;
        wait_ready(300);
        lock = 0;
        for (int c = 0; c < 3 + MR * (PRC + LT) - 10; c++) tick();
        check("retries_not_yet_fault", 32'(fault_o), 32'd0);
        for (int c = 0; c < 12; c++) tick();
        check("retries_full_fault", 32'(fault_o), 32'd1);

        // Lock drop in RELEASE right after two domains are out of reset
        lock = 1; sw = 1; tick(); sw = 0;
        i = 0;
        while (dom_rst_n_o != 3'b011 && i < 300) begin tick(); i++; end
        check("reach_011", 32'(dom_rst_n_o), 32'b011);
        lock = 0; tick(); lock = 1; tick(); tick();
        check("release_abort", 32'({pll_rst_o, dom_rst_n_o, ready_o}), 32'b1_000_0);
        wait_ready(300);

        // Repeated lock loss in RUN saturates the counter
        for (int r = 0; r < 300; r++) begin
            wait_ready(300);
            lock = 0; tick(); lock = 1; tick(); tick();
        end
        check("loss_saturated", 32'(lock_loss_cnt_o), 32'd255);

        // Reset coinciding with sw request and lock loss in RUN
        wait_ready(300);
        lock = 0; tick(); tick();
        rst_n = 0; sw = 1; tick();
        check("rst_wins", dut_outs(), 32'({1'b1, 3'b000, 1'b0, 1'b0, 8'd0}));
        rst_n = 1; sw = 0; lock = 1;
        wait_ready(300);

        // Randomized stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            sw    = ($urandom_range(0, 299) == 0);
            lock  = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Clock/reset sequencer that brings up the system PLL and releases the downstream reset domains in a fixed order. Runs on the free-running board clock, drives the PLL reset, and watches the PLL lock through an internal synchronizer. It retries PLL bring-up on lock timeout, re-sequences on lock loss or software reset request, and reports ready, fault and lock-loss status. It is the control layer above the PLL plus per-domain reset synchronizers in the system control block.

## Interface
- `N_DOM`, 3: number of sequenced reset domains, 1..8
- `PLL_RST_CYC`, 8: cycles `pll_rst_o` is held high per bring-up attempt, ≥2
- `LOCK_TIMEOUT`, 1024: cycles allowed for lock per attempt, ≥4
- `STAGE_DLY`, 16: cycles between successive domain releases, ≥1
- `MAX_RETRY`, 3: failed attempts tolerated before fault, ≥1
- `clk_i` in 1: free-running board clock, not PLL-derived
- `rst_n_i` in 1: reset, synchronous, active-low
- `pll_locked_i` in 1: PLL lock, asynchronous; 2-flop synchronized internally to `lock_s`
- `sw_rst_req_i` in 1: single-cycle software re-sequence request
- `pll_rst_o` out 1: PLL reset, active-high, registered
- `dom_rst_n_o` out N_DOM: per-domain reset, active-low, registered; bit 0 released first
- `ready_o` out 1: all domains released, PLL locked
- `fault_o` out 1: retries exhausted
- `lock_loss_cnt_o` out 8: saturating count of lock losses seen in RUN

## Operation
- Reset values: `pll_rst_o`=1, `dom_rst_n_o`=0, `ready_o`=0, `fault_o`=0, `lock_loss_cnt_o`=0, state PLL_RST, all counters and retry count 0, sync flops 0.
- Cycle counter `cnt` is sized for max(PLL_RST_CYC, LOCK_TIMEOUT, N_DOM·STAGE_DLY). Retry count `rty` is sized for MAX_RETRY.
- PLL_RST: `pll_rst_o`=1, all domains in reset.
  - `cnt` counts to PLL_RST_CYC-1, then the state goes to WAIT_LOCK and `cnt` is cleared.
- WAIT_LOCK: `pll_rst_o`=0.
  - `lock_s`=1 → RELEASE, `cnt` cleared.
  - Else when `cnt`=LOCK_TIMEOUT-1, `rty` increments. If the new `rty` equals MAX_RETRY → FAULT, else → PLL_RST.
  - Stale lock is not possible, because the PLL was held in reset for ≥2 cycles.
- RELEASE: `dom_rst_n_o[k]` goes high on the edge where `cnt` reaches (k+1)·STAGE_DLY-1. Released bits stay high.
  - After bit N_DOM-1 is released, the state goes to RUN on the next edge.
  - `rty` is cleared on entry.
- RUN: `ready_o`=1, all domains released, `pll_rst_o`=0.
- FAULT: `fault_o`=1, `pll_rst_o`=1, all domains in reset.
  - Only `rst_n_i` or `sw_rst_req_i` exits FAULT. Either one clears `fault_o` and `rty` and goes to PLL_RST.
- Abort: `lock_s`=0 in RELEASE or RUN, or `sw_rst_req_i`=1 in any state, has the same effect:
  - Next edge: all `dom_rst_n_o`=0, `ready_o`=0, `pll_rst_o`=1.
  - State → PLL_RST, `cnt` and `rty` cleared.
- `lock_loss_cnt_o` increments only on lock loss in RUN. It saturates at 255 and is cleared only by `rst_n_i`.
- Priority when events coincide in one cycle:
  1. `rst_n_i`
  2. `sw_rst_req_i`
  3. lock loss
  4. timeout / stage progression
- Lock loss together with `sw_rst_req_i` in RUN still increments `lock_loss_cnt_o`.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Lock-to-action latency: `pll_locked_i` change → `lock_s` after 2 edges → state reaction on the 3rd edge.
- Bring-up with lock present immediately after PLL reset, measured from the first edge sampling `rst_n_i`=1:
  - `pll_rst_o` falls at edge PLL_RST_CYC.
  - `dom_rst_n_o[0]` rises STAGE_DLY edges after RELEASE entry.
  - `ready_o` rises 1 edge after `dom_rst_n_o[N_DOM-1]`.
- Abort response: outputs reach reset state on the edge after the trigger is sampled.
- `rst_n_i` low mid-sequence: all outputs take reset values on that edge, regardless of state.

## Test plan
- Nominal bring-up, defaults, lock asserted 20 cycles after `pll_rst_o` falls:
  - `pll_rst_o` high for 8 cycles.
  - `dom_rst_n_o` goes 001, 011, 111 at 16-cycle spacing.
  - `ready_o`=1 one cycle later.
  - `fault_o`=0 and `lock_loss_cnt_o`=0 throughout.
- Lock never asserts:
  - Exactly 3 `pll_rst_o` pulses of 8 cycles each, separated by 1024-cycle waits.
  - Then `fault_o`=1, `pll_rst_o` held high.
  - A single `sw_rst_req_i` pulse clears the fault and restarts the sequence.
- Lock on the 2nd attempt:
  - `rty` returns to 0 and normal release follows.
  - A later timeout still allows a full 3 attempts.
- Lock drop in RUN for 1 cycle, after sync:
  - All domains reset within 3 edges, `ready_o`=0, `lock_loss_cnt_o`=1, full re-sequence.
  - Repeat 300 times: count saturates at 255.
- Lock drop in RELEASE just after `dom_rst_n_o`=011:
  - Domains return to 000, PLL reset reasserted, no RUN entry until re-sequence completes.
- `rst_n_i` low for 1 cycle in RUN together with `sw_rst_req_i` and lock loss:
  - Reset values win, including `lock_loss_cnt_o`=0.
  - Sequence restarts from PLL_RST.
